// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around the data-memory arbiter.
// slave = arbiter view; master = requesters plus the memory (the bench side).
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_rvalid;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata, cpu_rvalid,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ack, dbg_rdata, dbg_rvalid,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ack, dbg_rdata, dbg_rvalid,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data memory between the CPU EX stage and a debug port.
// CPU has priority; a starvation counter forces a debug grant after MAX_WAIT lost cycles.
module dmem_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input logic            clk,
   input logic            rst_n,
   dmem_arbiter_if.slave  bus
);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   starve_cnt, starve_cnt_n;
   logic               dbg_win, cpu_win;

   // State and starvation counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= CNT_W'(0);
      end else begin
         state      <= state_n;
         starve_cnt <= starve_cnt_n;
      end
   end

   // Arbitration, sequencing and (reset-gated) combinational outputs
   always_comb begin
      state_n        = state;
      starve_cnt_n   = starve_cnt;
      dbg_win        = 1'b0;
      cpu_win        = 1'b0;
      bus.cpu_stall  = 1'b0;
      bus.cpu_rdata  = DATA_W'(0);
      bus.cpu_rvalid = 1'b0;
      bus.dbg_ack    = 1'b0;
      bus.dbg_rdata  = DATA_W'(0);
      bus.dbg_rvalid = 1'b0;
      bus.mem_en     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = ADDR_W'(0);
      bus.mem_wdata  = DATA_W'(0);

      if (rst_n) begin
         case (state)
            IDLE: begin
               dbg_win = bus.dbg_req &
                         (!bus.cpu_req || starve_cnt == CNT_W'(MAX_WAIT));
               cpu_win = bus.cpu_req & !dbg_win;
               if (dbg_win) begin
                  bus.mem_en    = 1'b1;
                  bus.mem_we    = bus.dbg_we;
                  bus.mem_addr  = bus.dbg_addr;
                  bus.mem_wdata = bus.dbg_wdata;
                  bus.dbg_ack   = 1'b1;
                  bus.cpu_stall = bus.cpu_req;
                  starve_cnt_n  = CNT_W'(0);
                  if (!bus.dbg_we) state_n = DBG_RD;
               end else if (cpu_win) begin
                  bus.mem_en    = 1'b1;
                  bus.mem_we    = bus.cpu_we;
                  bus.mem_addr  = bus.cpu_addr;
                  bus.mem_wdata = bus.cpu_wdata;
                  bus.cpu_stall = !bus.cpu_we;
                  if (!bus.cpu_we) state_n = CPU_RD;
                  if (bus.dbg_req && starve_cnt < CNT_W'(MAX_WAIT))
                     starve_cnt_n = starve_cnt + CNT_W'(1);
               end
            end
            CPU_RD: begin
               bus.cpu_rvalid = 1'b1;
               bus.cpu_rdata  = bus.mem_rdata;
               state_n        = IDLE;
            end
            DBG_RD: begin
               bus.dbg_rvalid = 1'b1;
               bus.dbg_rdata  = bus.mem_rdata;
               bus.cpu_stall  = bus.cpu_req;
               state_n        = IDLE;
            end
            default: state_n = IDLE;
         endcase
         // A withdrawn debug request never accrues starvation credit
         if (!bus.dbg_req) starve_cnt_n = CNT_W'(0);
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small synchronous-read memory model.
module tb_dmem_arbiter;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle read latency memory, word indexed
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
   endtask

   task automatic dbg(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      bus.mem_rdata = 32'h0;
      rst_n = 1'b0;
      cpu(1'b1, 1'b1, 32'h10, 32'h37);
      dbg(1'b1, 1'b1, 32'h80, 32'hAA);
      #1;

      // Reset with both requests high: everything quiet
      cyc(); cyc();
      chk("rst_stall",  32'(bus.cpu_stall),  32'h0);
      chk("rst_ack",    32'(bus.dbg_ack),    32'h0);
      chk("rst_crv",    32'(bus.cpu_rvalid), 32'h0);
      chk("rst_drv",    32'(bus.dbg_rvalid), 32'h0);
      chk("rst_crd",    bus.cpu_rdata,       32'h0);
      chk("rst_drd",    bus.dbg_rdata,       32'h0);
      chk("rst_men",    32'(bus.mem_en),     32'h0);
      chk("rst_mwe",    32'(bus.mem_we),     32'h0);
      chk("rst_maddr",  bus.mem_addr,        32'h0);
      chk("rst_mwdata", bus.mem_wdata,       32'h0);

      // Release: CPU write of 0x37 to 0x10 wins the first edge
      rst_n = 1'b1;
      #1;
      chk("wr_men",   32'(bus.mem_en),    32'h1);
      chk("wr_mwe",   32'(bus.mem_we),    32'h1);
      chk("wr_addr",  bus.mem_addr,       32'h10);
      chk("wr_data",  bus.mem_wdata,      32'h37);
      chk("wr_stall", 32'(bus.cpu_stall), 32'h0);
      chk("wr_noack", 32'(bus.dbg_ack),   32'h0);
      cyc();

      // CPU read of 0x10: one stall cycle then data
      dbg(1'b0, 1'b0, 32'h0, 32'h0);
      cpu(1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      chk("rd_men",   32'(bus.mem_en),     32'h1);
      chk("rd_mwe",   32'(bus.mem_we),     32'h0);
      chk("rd_addr",  bus.mem_addr,        32'h10);
      chk("rd_stall", 32'(bus.cpu_stall),  32'h1);
      chk("rd_rv0",   32'(bus.cpu_rvalid), 32'h0);
      cyc();
      chk("rd_rv1",    32'(bus.cpu_rvalid), 32'h1);
      chk("rd_data",   bus.cpu_rdata,       32'h37);
      chk("rd_stall1", 32'(bus.cpu_stall),  32'h0);
      chk("rd_noiss",  32'(bus.mem_en),     32'h0);
      cyc();
      cpu(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("idle_rv",  32'(bus.cpu_rvalid), 32'h0);
      chk("idle_rd",  bus.cpu_rdata,       32'h0);
      chk("idle_men", 32'(bus.mem_en),     32'h0);
      cyc();

      // Debug preload then readback
      dbg(1'b1, 1'b1, 32'h40, 32'h5);
      #1;
      chk("dw_ack",   32'(bus.dbg_ack),   32'h1);
      chk("dw_mwe",   32'(bus.mem_we),    32'h1);
      chk("dw_addr",  bus.mem_addr,       32'h40);
      chk("dw_data",  bus.mem_wdata,      32'h5);
      chk("dw_stall", 32'(bus.cpu_stall), 32'h0);
      cyc();
      dbg(1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      chk("dr_ack", 32'(bus.dbg_ack), 32'h1);
      chk("dr_mwe", 32'(bus.mem_we),  32'h0);
      cyc();
      dbg(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("dr_rv",    32'(bus.dbg_rvalid), 32'h1);
      chk("dr_data",  bus.dbg_rdata,       32'h5);
      chk("dr_ack0",  32'(bus.dbg_ack),    32'h0);
      chk("dr_noiss", 32'(bus.mem_en),     32'h0);
      cyc();

      // Starvation: CPU writes every cycle, debug write held
      dbg(1'b1, 1'b1, 32'h44, 32'h99);
      for (int i = 0; i < 4; i++) begin
         cpu(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'(i));
         #1;
         chk("st_cpu_ack",  32'(bus.dbg_ack),   32'h0);
         chk("st_cpu_addr", bus.mem_addr,       32'h100 + 32'(4 * i));
         chk("st_cpu_stl",  32'(bus.cpu_stall), 32'h0);
         cyc();
      end
      cpu(1'b1, 1'b1, 32'h110, 32'h4);
      #1;
      chk("st_dbg_ack",  32'(bus.dbg_ack),   32'h1);
      chk("st_dbg_stl",  32'(bus.cpu_stall), 32'h1);
      chk("st_dbg_addr", bus.mem_addr,       32'h44);
      chk("st_dbg_data", bus.mem_wdata,      32'h99);
      cyc();
      dbg(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("st_after_addr", bus.mem_addr,       32'h110);
      chk("st_after_stl",  32'(bus.cpu_stall), 32'h0);
      chk("st_after_ack",  32'(bus.dbg_ack),   32'h0);
      cyc();

      // CPU read of 0x40 collides with a debug read of 0x10
      cpu(1'b1, 1'b0, 32'h40, 32'h0);
      dbg(1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      chk("co_t0_ack",  32'(bus.dbg_ack),   32'h0);
      chk("co_t0_stl",  32'(bus.cpu_stall), 32'h1);
      chk("co_t0_addr", bus.mem_addr,       32'h40);
      cyc();
      chk("co_t1_ack",  32'(bus.dbg_ack),    32'h0);
      chk("co_t1_rv",   32'(bus.cpu_rvalid), 32'h1);
      chk("co_t1_data", bus.cpu_rdata,       32'h5);
      chk("co_t1_men",  32'(bus.mem_en),     32'h0);
      cyc();
      cpu(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("co_t2_ack",  32'(bus.dbg_ack), 32'h1);
      chk("co_t2_addr", bus.mem_addr,     32'h10);
      cyc();
      dbg(1'b0, 1'b0, 32'h0, 32'h0);
      cpu(1'b1, 1'b1, 32'h48, 32'h77);
      #1;
      chk("co_t3_rv",   32'(bus.dbg_rvalid), 32'h1);
      chk("co_t3_data", bus.dbg_rdata,       32'h37);
      chk("co_t3_stl",  32'(bus.cpu_stall),  32'h1);
      chk("co_t3_men",  32'(bus.mem_en),     32'h0);
      cyc();
      chk("co_t4_men", 32'(bus.mem_en),    32'h1);
      chk("co_t4_stl", 32'(bus.cpu_stall), 32'h0);
      cyc();

      // Reset asserted during CPU_RD drops the pending read
      cpu(1'b1, 1'b0, 32'h10, 32'h0);
      cyc();
      chk("mr_rv_pre", 32'(bus.cpu_rvalid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mr_rv",  32'(bus.cpu_rvalid), 32'h0);
      chk("mr_stl", 32'(bus.cpu_stall),  32'h0);
      chk("mr_rd",  bus.cpu_rdata,       32'h0);
      cpu(1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
      rst_n = 1'b1;
      #1;
      chk("mr_rel_men", 32'(bus.mem_en),     32'h0);
      chk("mr_rel_rv",  32'(bus.cpu_rvalid), 32'h0);
      cyc();
      cpu(1'b1, 1'b1, 32'h4C, 32'h1);
      #1;
      chk("mr_idle_men", 32'(bus.mem_en),    32'h1);
      chk("mr_idle_stl", 32'(bus.cpu_stall), 32'h0);
      cyc();
      cpu(1'b0, 1'b0, 32'h0, 32'h0);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
